// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared VDP constants and types (VRAM geometry, owner tags).
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;

  // Which requester owned the VRAM port in a given cycle
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_REN   = 2'd1,
    OWN_IO_RD = 2'd2,
    OWN_IO_WR = 2'd3
  } vram_owner_t;

endpackage
`default_nettype wire

// File: rtl/vdp_io_req_buf.sv
`default_nettype none
// ============================================================================
// Module      : vdp_io_req_buf
// Description : Single-entry I/O request buffer. Captures an io_go pulse when
//               empty (or when its current entry is leaving this cycle) and
//               flags a dropped request with a one-cycle overrun pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_io_req_buf #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              buf_valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              overrun
);

  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_overrun;
  logic              w_capture;

  // A slot is free if empty or if the entry is granted in this same cycle
  assign w_capture = go && (!r_valid || clear);

  // Entry capture/clear and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= go && r_valid && !clear;
      if (w_capture) begin
        r_valid <= 1'b1;
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end else if (clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign buf_valid = r_valid;
  assign buf_we    = r_we;
  assign buf_addr  = r_addr;
  assign buf_wdata = r_wdata;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/vdp_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vdp_vram_arbiter
// Description : Single-port VRAM arbiter between the render fetcher (priority)
//               and the CPU I/O path. A wait counter forces a buffered I/O
//               request through after IO_MAX_WAIT lost cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_vram_arbiter
  import vdp_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter int IO_MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_ack,
  output logic              ren_rvalid,
  output logic [DATA_W-1:0] ren_rdata,
  input  logic              io_go,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_done,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_pending,
  output logic              io_overrun,
  output logic              screen_busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  localparam logic [7:0] c_max_wait = 8'(IO_MAX_WAIT);

  logic              w_buf_valid;
  logic              w_buf_we;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_wdata;
  logic              w_io_grant;
  logic              w_ren_grant;
  vram_owner_t       w_owner;

  logic [7:0]        r_wait_cnt;
  vram_owner_t       r_last_owner;
  logic [ADDR_W-1:0] r_addr_shadow;
  logic [DATA_W-1:0] r_io_rdata;
  logic              r_screen_busy;

  vdp_io_req_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_buf (
    .clk       (clk),
    .rst       (rst),
    .go        (io_go),
    .we        (io_we),
    .addr      (io_addr),
    .wdata     (io_wdata),
    .clear     (w_io_grant),
    .buf_valid (w_buf_valid),
    .buf_we    (w_buf_we),
    .buf_addr  (w_buf_addr),
    .buf_wdata (w_buf_wdata),
    .overrun   (io_overrun)
  );

  // Grant decision: I/O wins when render is idle or the I/O entry has starved
  always_comb begin
    w_io_grant  = w_buf_valid && (!ren_req || (r_wait_cnt == c_max_wait));
    w_ren_grant = !w_io_grant && ren_req;
    if (w_io_grant)
      w_owner = w_buf_we ? OWN_IO_WR : OWN_IO_RD;
    else if (w_ren_grant)
      w_owner = OWN_REN;
    else
      w_owner = OWN_NONE;
  end

  // VRAM port mux; the address parks on its last value when nobody owns it
  always_comb begin
    vram_addr  = r_addr_shadow;
    vram_we    = 1'b0;
    vram_wdata = '0;
    if (w_io_grant) begin
      vram_addr  = w_buf_addr;
      vram_we    = w_buf_we;
      vram_wdata = w_buf_wdata;
    end else if (w_ren_grant) begin
      vram_addr = ren_addr;
    end
  end

  // Completion tag, starvation counter, address shadow and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_last_owner  <= OWN_NONE;
      r_addr_shadow <= '0;
      r_io_rdata    <= '0;
      r_screen_busy <= 1'b0;
    end else begin
      r_last_owner  <= w_owner;
      r_addr_shadow <= vram_addr;
      r_screen_busy <= w_ren_grant;
      if (w_io_grant || !w_buf_valid)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != c_max_wait)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      // Read data is on vram_rdata during the io_done cycle; held afterwards
      if (r_last_owner == OWN_IO_RD)
        r_io_rdata <= vram_rdata;
    end
  end

  assign ren_ack     = w_ren_grant;
  assign ren_rvalid  = (r_last_owner == OWN_REN);
  assign ren_rdata   = vram_rdata;
  assign io_done     = (r_last_owner == OWN_IO_RD) || (r_last_owner == OWN_IO_WR);
  assign io_rdata    = r_io_rdata;
  assign io_pending  = w_buf_valid;
  assign screen_busy = r_screen_busy;

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_vram_arbiter
// Description : Scoreboard bench for vdp_vram_arbiter with a VRAM model and a
//               deadline-based reference of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_vram_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren_req = 1'b0;
  logic [13:0] ren_addr = '0;
  logic        ren_ack, ren_rvalid;
  logic [7:0]  ren_rdata;
  logic        io_go = 1'b0, io_we = 1'b0;
  logic [13:0] io_addr = '0;
  logic [7:0]  io_wdata = '0;
  logic        io_done, io_pending, io_overrun, screen_busy;
  logic [7:0]  io_rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = '0;

  vdp_vram_arbiter #(.ADDR_W(14), .DATA_W(8), .IO_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_ack(ren_ack),
    .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
    .io_go(io_go), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_done(io_done), .io_rdata(io_rdata), .io_pending(io_pending),
    .io_overrun(io_overrun), .screen_busy(screen_busy),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  // VRAM macro: synchronous write, registered read
  logic [7:0] mem [0:16383];
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  typedef struct { int t; logic [7:0] d; } exp_t;
  exp_t q_ren[$];
  exp_t q_rd[$];
  int   q_io[$];
  int   q_ovr[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference state: one pending request with the cycle by which it must issue
  logic [7:0]  m_mem [0:16383];
  bit          m_pv = 0;
  bit          m_pw;
  logic [13:0] m_pa;
  logic [7:0]  m_pd;
  int          m_deadline;
  logic [13:0] m_shadow = '0;

  // One cycle: drive at negedge, check combinational outputs, advance the model
  task automatic step(input bit rq, input logic [13:0] ra, input bit go, input bit we,
                      input logic [13:0] a, input logic [7:0] d, input bit r, output bit won);
    bit          io_win, ren_win;
    logic [13:0] e_addr;
    bit          e_we;
    @(negedge clk);
    ren_req = rq; ren_addr = ra; io_go = go; io_we = we; io_addr = a; io_wdata = d; rst = r;
    #1;
    io_win  = m_pv && (!rq || cyc >= m_deadline);
    ren_win = !io_win && rq;
    e_addr  = io_win ? m_pa : (ren_win ? ra : m_shadow);
    e_we    = io_win && m_pw;
    chk("ren_ack", ren_ack, ren_win);
    chk("io_pending", io_pending, m_pv);
    chk("vram_we", vram_we, e_we);
    chk("vram_addr", vram_addr, e_addr);
    if (e_we) chk("vram_wdata", vram_wdata, m_pd);
    if (!r) begin
      if (ren_win) q_ren.push_back('{cyc + 1, m_mem[ra]});
      if (io_win) begin
        q_io.push_back(cyc + 1);
        if (!m_pw) q_rd.push_back('{cyc + 2, m_mem[m_pa]});
      end
      if (go && m_pv && !io_win) q_ovr.push_back(cyc + 1);
    end else begin
      // A read granted last cycle never gets its data captured
      while (q_rd.size() > 0 && q_rd[$].t == cyc + 1) void'(q_rd.pop_back());
      q_rd.push_back('{cyc + 1, 8'h00});
    end
    if (io_win && m_pw) m_mem[m_pa] = m_pd;
    if (r) begin
      m_pv = 0;
    end else if (go && (!m_pv || io_win)) begin
      m_pv = 1; m_pw = we; m_pa = a; m_pd = d;
      m_deadline = cyc + 1 + MAXW;
    end else if (io_win) begin
      m_pv = 0;
    end
    m_shadow = r ? 14'h0 : e_addr;
    won = ren_win;
  endtask

  // Monitor: registered outputs against the scoreboard queues
  bit         e_b;
  bit         rd_known = 0;
  logic [7:0] rd_val;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    e_b = (q_ren.size() > 0) && (q_ren[0].t == cyc);
    chk("ren_rvalid", ren_rvalid, e_b);
    chk("screen_busy", screen_busy, e_b);
    if (e_b) begin
      chk("ren_rdata", ren_rdata, q_ren[0].d);
      void'(q_ren.pop_front());
    end
    e_b = (q_io.size() > 0) && (q_io[0] == cyc);
    chk("io_done", io_done, e_b);
    if (e_b) void'(q_io.pop_front());
    e_b = (q_ovr.size() > 0) && (q_ovr[0] == cyc);
    chk("io_overrun", io_overrun, e_b);
    if (e_b) void'(q_ovr.pop_front());
    while (q_rd.size() > 0 && q_rd[0].t <= cyc) begin
      rd_val   = q_rd[0].d;
      rd_known = 1;
      void'(q_rd.pop_front());
    end
    if (rd_known) chk("io_rdata", io_rdata, rd_val);
  end

  function automatic logic [13:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 14'h3800 + 14'($urandom_range(0, 7));
    return 14'h0120 + 14'($urandom_range(0, 7));
  endfunction

  bit          won;
  bit          rq;
  logic [13:0] ra;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]   = 8'(i * 7 + 3);
      m_mem[i] = 8'(i * 7 + 3);
    end
    // Reset
    step(0, 14'h0, 0, 0, 14'h0, 8'h0, 1, won);
    step(0, 14'h0, 0, 0, 14'h0, 8'h0, 1, won);
    step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    // Idle write then read back of 0x0123
    step(0, 14'h0, 1, 1, 14'h0123, 8'hA5, 0, won);
    repeat (3) step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    step(0, 14'h0, 1, 0, 14'h0123, 8'h00, 0, won);
    repeat (4) step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    // Render burst 0x3800..0x3803
    for (int i = 0; i < 4; i++) step(1, 14'h3800 + 14'(i), 0, 0, 14'h0, 8'h0, 0, won);
    step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    // Starvation bound: continuous render plus one I/O write
    step(1, 14'h3810, 1, 1, 14'h0124, 8'h3C, 0, won);
    for (int i = 0; i < 8; i++) step(1, 14'h3811 + 14'(i), 0, 0, 14'h0, 8'h0, 0, won);
    // Back-to-back io_go under render: second one dropped
    step(1, 14'h3820, 1, 1, 14'h0125, 8'h11, 0, won);
    step(1, 14'h3821, 1, 1, 14'h0126, 8'h22, 0, won);
    for (int i = 0; i < 7; i++) step(1, 14'h3822, 0, 0, 14'h0, 8'h0, 0, won);
    step(0, 14'h0, 1, 0, 14'h0125, 8'h0, 0, won);
    step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    step(0, 14'h0, 1, 0, 14'h0126, 8'h0, 0, won);
    repeat (3) step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    // io_go coinciding with the grant of the buffered entry
    step(0, 14'h0, 1, 1, 14'h0127, 8'h77, 0, won);
    step(0, 14'h0, 1, 0, 14'h0127, 8'h00, 0, won);
    repeat (4) step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    // Reset in a render grant cycle with a buffered request outstanding
    step(1, 14'h3830, 1, 0, 14'h0120, 8'h0, 0, won);
    step(1, 14'h3831, 0, 0, 14'h0, 8'h0, 1, won);
    repeat (3) step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    // Randomized traffic
    rq = 0; ra = '0; won = 0;
    for (int i = 0; i < 800; i++) begin
      if (!rq || won) begin
        rq = ($urandom_range(0, 3) != 0);
        ra = rand_addr();
      end
      step(rq, ra, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rand_addr(),
           8'($urandom), ($urandom_range(0, 149) == 0), won);
    end
    repeat (MAXW + 4) step(0, 14'h0, 0, 0, 14'h0, 8'h0, 0, won);
    chk("drain", q_ren.size() + q_io.size() + q_ovr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vdp_vram_arbiter.md
# vdp_vram_arbiter

Single-port VRAM arbiter for the VDP. It shares one synchronous VRAM port between two requesters: the render engine's pattern/name-table fetcher and the CPU-side I/O path (`vdp_io` byte transfers). Render reads have priority, and a wait counter bounds I/O starvation. A one-entry buffer absorbs I/O requests so `vdp_io`'s single-cycle `VRAM_go` pulses are never dropped silently. The block sits between `vdp_io`, the render pipeline and the VRAM macro; its `screen_busy` output feeds `vdp_io`'s `screenBusy`.

## Interface
Parameters:
- `ADDR_W`, default 14: VRAM address width.
- `DATA_W`, default 8: VRAM data width.
- `IO_MAX_WAIT`, default 16: maximum number of cycles a buffered I/O request may lose to render before it is forced through. Legal range is 1..255.

Ports:
- `clk`  in  1  single system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `ren_req`  in  1  render read request (level); held until `ren_ack`.
- `ren_addr`  in  ADDR_W  render read address; stable while `ren_req` is high.
- `ren_ack`  out  1  combinational; high in the cycle the render address is issued to VRAM.
- `ren_rvalid`  out  1  registered; high one cycle after `ren_ack`.
- `ren_rdata`  out  DATA_W  equals `vram_rdata`; valid when `ren_rvalid` is high.
- `io_go`  in  1  one-cycle I/O request pulse.
- `io_we`  in  1  request type: 1 = write, 0 = read. Sampled with `io_go`.
- `io_addr`  in  ADDR_W  I/O address. Sampled with `io_go`.
- `io_wdata`  in  DATA_W  I/O write data. Sampled with `io_go`.
- `io_done`  out  1  registered pulse one cycle after the I/O access is issued.
- `io_rdata`  out  DATA_W  registered; captured from `vram_rdata` on I/O read completion; held otherwise.
- `io_pending`  out  1  the I/O buffer is occupied.
- `io_overrun`  out  1  registered pulse; an `io_go` was dropped.
- `screen_busy`  out  1  registered; high in the cycle after any render grant.
- `vram_addr`  out  ADDR_W  VRAM address (combinational from the grant decision).
- `vram_we`  out  1  VRAM write enable (combinational).
- `vram_wdata`  out  DATA_W  VRAM write data (combinational).
- `vram_rdata`  in  DATA_W  VRAM read data, valid one cycle after the address is issued.

## Operation
- The I/O buffer holds a single entry (`we`, `addr`, `wdata`, `valid`).
  - `io_go` with the buffer empty captures the request. The earliest grant is the following cycle; there is no same-cycle bypass.
- The arbiter makes one grant per cycle. The `owner` decision is:
  - **OWN_IO**: the buffer is valid and either `ren_req`=0 or `wait_cnt`==`IO_MAX_WAIT`.
  - **OWN_REN**: otherwise, if `ren_req`=1.
  - **OWN_NONE**: otherwise.
- On OWN_REN: `vram_addr`=`ren_addr`, `vram_we`=0, `ren_ack`=1.
- On OWN_IO: `vram_addr`=`buf.addr`, `vram_we`=`buf.we`, `vram_wdata`=`buf.wdata`, and the buffer is cleared at the clock edge.
- On OWN_NONE: `vram_we`=0 and `vram_addr` holds its previous value (registered shadow).
- Completion tag: a 2-bit registered `last_owner` (NONE/REN/IO_RD/IO_WR) drives the next-cycle outputs:
  - REN → `ren_rvalid`.
  - IO_RD → `io_done`, with `io_rdata` latched.
  - IO_WR → `io_done`.
- `wait_cnt` (8 bits):
  - Increments each cycle the buffer is valid and the owner is not IO. It saturates at `IO_MAX_WAIT`.
  - Clears on an I/O grant or when the buffer is empty.
- Simultaneous events:
  - `io_go` in the same cycle the buffer is granted: the new request is captured, the buffer stays valid and `wait_cnt` restarts at 0.
  - `io_go` while the buffer is valid and not granted: the new request is dropped, `io_overrun` pulses next cycle, and the buffer contents are unchanged.
- Back-to-back grants are allowed every cycle, with no bubble between owners.

## Timing
- Reset (`rst`=1 at posedge):
  - Buffer invalid, `wait_cnt`=0, `last_owner`=NONE.
  - All registered outputs 0, including `io_rdata` and the `vram_addr` shadow.
  - Combinational outputs evaluate with the buffer empty.
- Reset mid-operation: an access issued in the cycle before reset produces no `ren_rvalid` or `io_done`. A buffered request is discarded.
- Latency:
  - Render: `ren_ack` in cycle N, data in N+1.
  - I/O, uncontended: `io_go` in N, issue in N+1, `io_done` in N+2.
  - I/O, worst case under continuous `ren_req`: issue at N+1+`IO_MAX_WAIT`.
- `screen_busy` follows a render grant by exactly 1 cycle.

## Structure
- Shared package `vdp_pkg`:
  - `VRAM_ADDR_W`=14, `VRAM_DATA_W`=8.
  - `typedef enum logic [1:0] {OWN_NONE, OWN_REN, OWN_IO_RD, OWN_IO_WR} vram_owner_t`.
- Sub-module `vdp_io_req_buf`: single-entry capture/clear buffer with an overrun flag. The arbiter top holds the grant logic, `wait_cnt`, `last_owner` and the VRAM mux.

## Test plan
- Idle VRAM, `io_go`=1 with `io_we`=1, `addr`=0x0123, `wdata`=0xA5 → `vram_we`=1 at 0x0123 one cycle later and `io_done` the cycle after. A subsequent read of 0x0123 returns `io_rdata`=0xA5.
- `ren_req` held high with `addr` 0x3800..0x3803 → four consecutive `ren_ack` pulses, and `ren_rvalid` with data in the next cycle of each.
- `ren_req` held continuously plus one `io_go` with `IO_MAX_WAIT`=4 → the I/O access is issued exactly 5 cycles after `io_go`, and `ren_ack` is low only in that cycle.
- `io_go` twice in consecutive cycles while render is active → the second request is dropped, `io_overrun`=1 for one cycle, and the first request completes with its original data.
- `io_go` in the same cycle the buffer is granted → both requests complete in order, with no overrun.
- Assert `rst` in the cycle after a render grant → no `ren_rvalid`, `screen_busy`=0, `io_pending`=0 next cycle.
